// File: rtl/branch_unit_ras_pkg.sv
// Shared branch opcode encodings and FSM state type for the execute-stage
// branch unit and the decoder.
package branch_unit_ras_pkg;

  localparam logic [6:0] BR_FWD_C    = 7'd1;
  localparam logic [6:0] BR_FWD      = 7'd2;
  localparam logic [6:0] BR_BACK_C   = 7'd3;
  localparam logic [6:0] BR_BACK     = 7'd4;
  localparam logic [6:0] BR_FWD_OVF  = 7'd5;
  localparam logic [6:0] BR_FWD_UNF  = 7'd6;
  localparam logic [6:0] BR_BACK_OVF = 7'd7;
  localparam logic [6:0] BR_BACK_UNF = 7'd8;
  localparam logic [6:0] BR_CALL     = 7'd9;
  localparam logic [6:0] BR_RET      = 7'd10;
  localparam logic [6:0] BR_JMP_ABS  = 7'd11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address LIFO; pushing onto a full stack silently overwrites
// the oldest entry, and popping an empty stack is ignored.
module return_addr_stack
  import branch_unit_ras_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_dout,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

  logic [PC_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [PTR_W:0]   r_count;
  logic             w_doPop;

  assign o_full  = (r_count == CNT_MAX);
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_top - PTR_ONE];
  assign w_doPop = i_pop && !o_empty;

  // r_top points at the next free slot, which on a full stack is the oldest entry
  always_ff @(posedge clock_i) begin
    if (i_push) begin
      r_mem[r_top] <= i_din;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_top <= r_top + PTR_ONE;
      if (!o_full) begin
        r_count <= r_count + CNT_ONE;
      end
    end else if (w_doPop) begin
      r_top   <= r_top - PTR_ONE;
      r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_unit_ras.sv
// Execute-stage branch resolution: computes the next PC, drives a fixed-length
// front-end flush for taken branches and manages call/return through the RAS.
module branch_unit_ras
  import branch_unit_ras_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int DATA_W       = 16,
  parameter int RAS_DEPTH    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [6:0]        opCode_i,
  input  logic [DATA_W-1:0] pOperand_i,
  input  logic [DATA_W-1:0] sOperand_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [1:0]        opStat_i,
  input  logic              flushBack_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              flushBack_o,
  output logic              busy_o,
  output logic              rasOvf_o,
  output logic              rasUnf_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic [PC_W-1:0]  r_pc, w_pcNext;
  logic             r_flush, w_flushNext;
  logic             r_rasOvf, r_rasUnf;

  logic [PC_W-1:0]  w_p, w_tgtF, w_tgtB, w_pcInc, w_target, w_rasDout;
  logic             w_taken, w_push, w_pop, w_accept, w_condS;
  logic             w_rasFull, w_rasEmpty;

  if (DATA_W >= PC_W) begin : g_trunc
    assign w_p = pOperand_i[PC_W-1:0];
  end else begin : g_ext
    assign w_p = {{(PC_W-DATA_W){1'b0}}, pOperand_i};
  end

  assign w_tgtF   = pc_i + w_p;
  assign w_tgtB   = pc_i - w_p;
  assign w_pcInc  = pc_i + PC_W'(1);
  assign w_condS  = |sOperand_i;
  assign w_accept = (r_state == ST_IDLE) && enable_i && !flushBack_i;

  return_addr_stack #(
    .PC_W (PC_W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_pcInc),
    .o_dout (w_rasDout),
    .o_full (w_rasFull),
    .o_empty(w_rasEmpty)
  );

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_tgtF;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    if (w_accept) begin
      unique case (opCode_i)
        BR_FWD_C:    w_taken = w_condS;
        BR_FWD:      w_taken = 1'b1;
        BR_BACK_C:   begin w_taken = w_condS;     w_target = w_tgtB; end
        BR_BACK:     begin w_taken = 1'b1;        w_target = w_tgtB; end
        BR_FWD_OVF:  w_taken = opStat_i[1];
        BR_FWD_UNF:  w_taken = opStat_i[0];
        BR_BACK_OVF: begin w_taken = opStat_i[1]; w_target = w_tgtB; end
        BR_BACK_UNF: begin w_taken = opStat_i[0]; w_target = w_tgtB; end
        BR_CALL:     begin w_taken = 1'b1;        w_push   = 1'b1;   end
        // An empty-stack return falls through as a plain not-taken op
        BR_RET:      begin w_pop = 1'b1; w_taken = !w_rasEmpty; w_target = w_rasDout; end
        BR_JMP_ABS:  begin w_taken = 1'b1;        w_target = w_p;    end
        default:     w_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_pcNext    = r_pc;
    w_flushNext = r_flush;
    unique case (r_state)
      ST_IDLE: begin
        if (flushBack_i) begin
          w_pcNext    = pc_i;
          w_flushNext = 1'b0;
        end else if (w_taken) begin
          w_pcNext    = w_target;
          w_flushNext = 1'b1;
          w_cntNext   = CNT_INIT;
          w_stateNext = ST_FLUSH;
        end else begin
          w_pcNext    = w_pcInc;
          w_flushNext = 1'b0;
        end
      end
      ST_FLUSH: begin
        w_flushNext = 1'b1;
        if (r_cnt == '0) begin
          w_stateNext = ST_IDLE;
          w_flushNext = 1'b0;
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pc     <= '0;
      r_flush  <= 1'b0;
      r_rasOvf <= 1'b0;
      r_rasUnf <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_pc     <= w_pcNext;
      r_flush  <= w_flushNext;
      r_rasOvf <= w_push && w_rasFull;
      r_rasUnf <= w_pop && w_rasEmpty;
    end
  end

  assign pc_o        = r_pc;
  assign flushBack_o = r_flush;
  assign busy_o      = (r_state == ST_FLUSH);
  assign rasOvf_o    = r_rasOvf;
  assign rasUnf_o    = r_rasUnf;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed self-checking bench for branch_unit_ras with hand-computed expected
// next-PC, flush, busy and RAS overflow/underflow values.
module tb_branch_unit_ras;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [6:0]  opCode_i;
  logic [15:0] pOperand_i;
  logic [15:0] sOperand_i;
  logic [15:0] pc_i;
  logic [1:0]  opStat_i;
  logic        flushBack_i;
  logic [15:0] pc_o;
  logic        flushBack_o;
  logic        busy_o;
  logic        rasOvf_o;
  logic        rasUnf_o;

  int checkCount = 0;
  int errorCount = 0;

  branch_unit_ras #(
    .PC_W        (16),
    .DATA_W      (16),
    .RAS_DEPTH   (8),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .enable_i   (enable_i),
    .opCode_i   (opCode_i),
    .pOperand_i (pOperand_i),
    .sOperand_i (sOperand_i),
    .pc_i       (pc_i),
    .opStat_i   (opStat_i),
    .flushBack_i(flushBack_i),
    .pc_o       (pc_o),
    .flushBack_o(flushBack_o),
    .busy_o     (busy_o),
    .rasOvf_o   (rasOvf_o),
    .rasUnf_o   (rasUnf_o)
  );

  // 10 ns clock period
  always #5 clock_i = ~clock_i;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle just past the rising edge
  task automatic applyStimulus(input logic en, input logic [6:0] op,
                               input logic [15:0] p, input logic [15:0] s,
                               input logic [15:0] pc, input logic [1:0] stat,
                               input logic fb);
    enable_i    = en;
    opCode_i    = op;
    pOperand_i  = p;
    sOperand_i  = s;
    pc_i        = pc;
    opStat_i    = stat;
    flushBack_i = fb;
    @(posedge clock_i);
    #1;
  endtask

  // Idle cycles used to let a flush run out
  task automatic stepIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  initial begin
    reset_i = 1'b0;
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0);
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0);
    checkOutput("reset pc_o", pc_o, 32'h0);
    checkOutput("reset flush", flushBack_o, 32'h0);
    checkOutput("reset busy", busy_o, 32'h0);
    checkOutput("reset ovf", rasOvf_o, 32'h0);
    checkOutput("reset unf", rasUnf_o, 32'h0);
    reset_i = 1'b1;

    // Unconditional forward branch and full flush window
    applyStimulus(1'b1, 7'd2, 16'h5, 16'h0, 16'h0010, 2'b00, 1'b0);
    checkOutput("fwd pc", pc_o, 32'h15);
    checkOutput("fwd flush c1", flushBack_o, 32'h1);
    checkOutput("fwd busy c1", busy_o, 32'h1);
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0011, 2'b00, 1'b0);
    checkOutput("fwd pc hold", pc_o, 32'h15);
    checkOutput("fwd flush c2", flushBack_o, 32'h1);
    checkOutput("fwd busy c2", busy_o, 32'h1);
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0011, 2'b00, 1'b0);
    checkOutput("fwd flush end", flushBack_o, 32'h0);
    checkOutput("fwd busy end", busy_o, 32'h0);
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0011, 2'b00, 1'b0);
    checkOutput("idle pc+1", pc_o, 32'h12);

    // Conditional forward not taken, conditional backward taken
    applyStimulus(1'b1, 7'd1, 16'h5, 16'h0, 16'h0020, 2'b00, 1'b0);
    checkOutput("fwdc nt pc", pc_o, 32'h21);
    checkOutput("fwdc nt flush", flushBack_o, 32'h0);
    applyStimulus(1'b1, 7'd3, 16'h4, 16'h7, 16'h0020, 2'b00, 1'b0);
    checkOutput("backc pc", pc_o, 32'h1C);
    checkOutput("backc flush", flushBack_o, 32'h1);
    stepIdle(2);

    // Modular wrap in both directions
    applyStimulus(1'b1, 7'd4, 16'h5, 16'h0, 16'h0002, 2'b00, 1'b0);
    checkOutput("back wrap", pc_o, 32'hFFFD);
    stepIdle(2);
    applyStimulus(1'b1, 7'd2, 16'h3, 16'h0, 16'hFFFE, 2'b00, 1'b0);
    checkOutput("fwd wrap", pc_o, 32'h0001);
    stepIdle(2);

    // Nine calls overflow the 8-deep stack on the last one
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 7'd9, 16'h10, 16'h0, 16'h0100 + 16'(i), 2'b00, 1'b0);
      checkOutput("call pc", pc_o, 32'h110 + 32'(i));
      checkOutput("call ovf", rasOvf_o, (i == 8) ? 32'h1 : 32'h0);
      stepIdle(2);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 7'd10, 16'h0, 16'h0, 16'h0200, 2'b00, 1'b0);
      checkOutput("ret pc", pc_o, 32'h109 - 32'(i));
      checkOutput("ret flush", flushBack_o, 32'h1);
      checkOutput("ret unf", rasUnf_o, 32'h0);
      stepIdle(2);
    end
    applyStimulus(1'b1, 7'd10, 16'h0, 16'h0, 16'h0200, 2'b00, 1'b0);
    checkOutput("ret empty pc", pc_o, 32'h201);
    checkOutput("ret empty flush", flushBack_o, 32'h0);
    checkOutput("ret empty unf", rasUnf_o, 32'h1);
    stepIdle(1);
    checkOutput("unf pulse end", rasUnf_o, 32'h0);

    // Inputs ignored while flushing; reset mid-flush clears everything
    applyStimulus(1'b1, 7'd2, 16'h5, 16'h0, 16'h0030, 2'b00, 1'b0);
    applyStimulus(1'b1, 7'd2, 16'h9, 16'h0, 16'h0050, 2'b00, 1'b1);
    checkOutput("flush ignore pc", pc_o, 32'h35);
    checkOutput("flush ignore fb", flushBack_o, 32'h1);
    stepIdle(1);
    applyStimulus(1'b1, 7'd9, 16'h4, 16'h0, 16'h0060, 2'b00, 1'b0);
    checkOutput("call pre-reset", pc_o, 32'h64);
    reset_i = 1'b0;
    applyStimulus(1'b0, 7'd0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0);
    checkOutput("midflush rst pc", pc_o, 32'h0);
    checkOutput("midflush rst flush", flushBack_o, 32'h0);
    checkOutput("midflush rst busy", busy_o, 32'h0);
    reset_i = 1'b1;
    applyStimulus(1'b1, 7'd10, 16'h0, 16'h0, 16'h0070, 2'b00, 1'b0);
    checkOutput("ras cleared pc", pc_o, 32'h71);
    checkOutput("ras cleared unf", rasUnf_o, 32'h1);

    // Overflow/underflow-conditioned branches, default op, IDLE flushBack_i, JMP
    applyStimulus(1'b1, 7'd5, 16'h8, 16'h0, 16'h0040, 2'b10, 1'b0);
    checkOutput("fwd ovf pc", pc_o, 32'h48);
    stepIdle(2);
    applyStimulus(1'b1, 7'd6, 16'h8, 16'h0, 16'h0040, 2'b10, 1'b0);
    checkOutput("fwd unf nt pc", pc_o, 32'h41);
    checkOutput("fwd unf nt flush", flushBack_o, 32'h0);
    applyStimulus(1'b1, 7'd7, 16'h8, 16'h0, 16'h0040, 2'b10, 1'b0);
    checkOutput("back ovf pc", pc_o, 32'h38);
    stepIdle(2);
    applyStimulus(1'b1, 7'd12, 16'h8, 16'h1, 16'h0040, 2'b11, 1'b0);
    checkOutput("other op pc", pc_o, 32'h41);
    applyStimulus(1'b1, 7'd2, 16'h5, 16'h0, 16'h0080, 2'b00, 1'b1);
    checkOutput("fb_i pc", pc_o, 32'h80);
    checkOutput("fb_i flush", flushBack_o, 32'h0);
    applyStimulus(1'b1, 7'd11, 16'h1234, 16'h0, 16'h0090, 2'b00, 1'b0);
    checkOutput("jmp abs pc", pc_o, 32'h1234);
    checkOutput("jmp abs flush", flushBack_o, 32'h1);
    stepIdle(2);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
